logic_unit_stream: RTL and testbench
====================================

# logic_unit_stream

Parametrised, handshaked bitwise logic unit for the Hack datapath. It generalises the fixed 16-bit OR gate to any `WIDTH` and four selectable operations, with a registered, valid/ready-throttled result. It also has a fold mode that reduces a multi-beat packet of words to one word, an N-way reduction across time. It sits between a word source (RAM/ROM streamer or test harness) and any consumer that needs registered bitwise results.

## Interface
Parameters:
- `WIDTH`, 16: data width in bits (≥1).
- `MAX_BEATS`, 8: maximum beats per fold packet (≥2). `CW = $clog2(MAX_BEATS+1)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input beat present.
- `in_ready` out 1: unit accepts beat this cycle.
- `in_a` in WIDTH: operand A.
- `in_b` in WIDTH: operand B (ignored in fold mode).
- `in_op` in 2: 00 AND, 01 OR, 10 XOR, 11 NAND.
- `in_fold` in 1: 0 elementwise, 1 fold.
- `in_last` in 1: final beat of fold packet.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts result.
- `out_data` out WIDTH: result.
- `out_zero` out 1: `out_data == 0`.
- `out_count` out CW: beats consumed for this result.
- `out_trunc` out 1: fold terminated at MAX_BEATS without `in_last`.
- `out_parity` out 1: XOR of `out_data` bits (only with macro).

## Operation
- Beat accepted when `in_valid && in_ready`. `in_ready = !reset && (!out_valid || out_ready)`. This is combinational and is the same in both modes.
- State machine `IDLE`, `ACCUM`:
  - `IDLE`, accepted beat with `in_fold=0`: load `out_data = a OP b`, `out_count=1`, `out_trunc=0`, set `out_valid`. Stay in `IDLE`.
  - `IDLE`, accepted beat with `in_fold=1`: latch op/mode for the packet, `acc = in_a`, `cnt = 1`.
    - If `in_last`: emit `acc` with count 1 and stay in `IDLE`.
    - Otherwise go to `ACCUM`.
  - `ACCUM`, accepted beat: `acc = acc OP in_a` using the latched op (NAND: `~(acc & in_a)`), `cnt = cnt+1`. `in_op` and `in_fold` are ignored.
    - If `in_last`: emit with `out_trunc=0` and return to `IDLE`.
    - Else if `cnt+1 == MAX_BEATS`: emit with `out_trunc=1` and return to `IDLE`.
    - Otherwise stay in `ACCUM`.
- Emit: `out_data`, `out_count`, `out_trunc` and `out_valid=1` are loaded on the same edge.
- `out_valid` clears on `out_valid && out_ready` unless a new emit loads on the same edge. A simultaneous accept and emit keeps `out_valid=1` with the new data, giving full throughput.
- `out_zero` and `out_parity` are combinational from `out_data`.
- `in_last` in elementwise mode is ignored.

## Timing
- Reset (async assert) values: `out_valid=0`, `out_data=0`, `out_count=0`, `out_trunc=0`, state `IDLE`, `acc=0`, `cnt=0`. Consequently `out_zero=1`, `out_parity=0`, and `in_ready=0` while `reset` is high.
- Reset mid-packet discards the partial fold. An unaccepted output is lost.
- Elementwise latency: 1 cycle. A beat accepted at edge N gives `out_valid` after edge N. Sustained throughput is 1 beat/cycle with `out_ready` high.
- Fold latency: result valid after the edge accepting the last beat (or the MAX_BEATS-th beat).
- Backpressure: `out_data` and its flags hold stable while `out_valid && !out_ready`. No beat is accepted in that condition.
- Intermediate fold beats are also stalled by a pending unaccepted output.

## Configuration
- `LOGIC_UNIT_PARITY_EN` defined: `out_parity` port exists and equals `^out_data`.
- Not defined: `out_parity` is absent and no parity logic is built. All other behaviour is identical.

## Test plan
- Reset then elementwise OR, WIDTH=16, `a=0x00F0`, `b=0x0F01` -> `out_data=0x0FF1`, `out_count=1`, `out_zero=0`, one cycle after accept.
- Back-to-back elementwise AND/XOR/NAND with `a=0xFFFF`, `b=0x1234`, `out_ready=1` -> results `0x1234`, `0xEDCB`, `0xEDCB` on consecutive cycles, `in_ready` never low.
- Fold OR, 3 beats `0x0001`, `0x0010`, `0x0100` with `in_last` on beat 3 -> single result `0x0111`, `out_count=3`, `out_trunc=0`.
- Fold AND, 8 beats of `0xFFFF` with no `in_last`, MAX_BEATS=8 -> `out_data=0xFFFF`, `out_count=8`, `out_trunc=1`; the next beat starts a new packet.
- Backpressure: hold `out_ready=0` with a result pending -> `in_ready=0` and `out_data` stable for 5 cycles. Releasing it gives one accept and the next beat enters on the same edge.
- Assert `reset` mid-fold after 2 beats -> all outputs at reset values immediately. A fresh 1-beat fold of `0xA5A5` with `in_last` gives `out_count=1`, and with the macro defined `out_parity=0`.

Source files
------------

// File: rtl/logic_unit_stream.sv
`default_nettype none
// ============================================================================
//  Module   : logic_unit_stream
//  Purpose  : Handshaked WIDTH-bit bitwise logic unit (AND/OR/XOR/NAND) with
//             a registered valid/ready output and a fold mode that reduces a
//             multi-beat packet of operand-A words to a single word.
//  Options  : LOGIC_UNIT_PARITY_EN adds the out_parity output (^out_data).
//  Revision : 1.0 - initial release
// ============================================================================
module logic_unit_stream #(
    parameter int WIDTH     = 16,
    parameter int MAX_BEATS = 8,
    localparam int CW       = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_fold,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [CW-1:0]    out_count,
    output logic             out_trunc
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    localparam logic [1:0]    c_OP_AND  = 2'b00;
    localparam logic [1:0]    c_OP_OR   = 2'b01;
    localparam logic [1:0]    c_OP_XOR  = 2'b10;
    localparam logic [CW-1:0] c_MAX_CNT = CW'(MAX_BEATS);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [CW-1:0]      out_count_q, out_count_d;
    logic               out_trunc_q, out_trunc_d;

    logic               w_accept;
    logic [WIDTH-1:0]   w_fold_val;
    logic [CW-1:0]      w_cnt_next;

    function automatic logic [WIDTH-1:0] f_apply(input logic [1:0]       op,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        case (op)
            c_OP_AND: f_apply = x & y;
            c_OP_OR:  f_apply = x | y;
            c_OP_XOR: f_apply = x ^ y;
            default:  f_apply = ~(x & y);
        endcase
    endfunction

    // Ready is shared by both modes: free output slot or one being drained now.
    assign in_ready   = !reset && (!out_valid_q || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_fold_val = f_apply(op_q, acc_q, in_a);
    assign w_cnt_next = cnt_q + CW'(1);

    // Next-state, accumulator and output-register load logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_trunc_d = out_trunc_q;

        // Drain first; an emit below on the same edge overrides it.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (w_accept) begin
            case (state_q)
                S_IDLE: begin
                    if (!in_fold) begin
                        out_valid_d = 1'b1;
                        out_data_d  = f_apply(in_op, in_a, in_b);
                        out_count_d = CW'(1);
                        out_trunc_d = 1'b0;
                    end else begin
                        op_d  = in_op;
                        acc_d = in_a;
                        cnt_d = CW'(1);
                        if (in_last) begin
                            out_valid_d = 1'b1;
                            out_data_d  = in_a;
                            out_count_d = CW'(1);
                            out_trunc_d = 1'b0;
                        end else begin
                            state_d = S_ACCUM;
                        end
                    end
                end
                default: begin
                    acc_d = w_fold_val;
                    cnt_d = w_cnt_next;
                    if (in_last || (w_cnt_next == c_MAX_CNT)) begin
                        out_valid_d = 1'b1;
                        out_data_d  = w_fold_val;
                        out_count_d = w_cnt_next;
                        // Truncation only when the beat limit ends the packet.
                        out_trunc_d = !in_last;
                        state_d     = S_IDLE;
                    end
                end
            endcase
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_trunc_q <= out_trunc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_trunc = out_trunc_q;
    assign out_zero  = (out_data_q == '0);

`ifdef LOGIC_UNIT_PARITY_EN
    assign out_parity = ^out_data_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logic_unit_stream
//  Purpose  : Directed self-checking bench for logic_unit_stream
//             (WIDTH=16, MAX_BEATS=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_logic_unit_stream;

    localparam int WIDTH     = 16;
    localparam int MAX_BEATS = 8;
    localparam int CW        = $clog2(MAX_BEATS + 1);

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             in_fold;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic [CW-1:0]    out_count;
    logic             out_trunc;
`ifdef LOGIC_UNIT_PARITY_EN
    logic             out_parity;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic_unit_stream #(
        .WIDTH     (WIDTH),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_fold   (in_fold),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_count (out_count),
        .out_trunc (out_trunc)
`ifdef LOGIC_UNIT_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [15:0] a, input logic [15:0] b,
                            input logic [1:0] op, input logic fold, input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_fold  = fold;
        in_last  = last;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        in_fold = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        #12;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_count !== 4'd0 ||
            out_trunc !== 1'b0 || out_zero !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: valid=%b data=%h cnt=%0d trunc=%b zero=%b rdy=%b, want 0 0000 0 0 1 0",
                     out_valid, out_data, out_count, out_trunc, out_zero, in_ready);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b want 1", in_ready);
        end
    endtask

    task automatic test_elem_or();
        out_ready = 1'b0;
        set_beat(16'h00F0, 16'h0F01, 2'b01, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0FF1 || out_count !== 4'd1 ||
            out_zero !== 1'b0 || out_trunc !== 1'b0) begin
            n_fail++;
            $display("FAIL elem_or: valid=%b data=%h cnt=%0d zero=%b trunc=%b, want 1 0ff1 1 0 0",
                     out_valid, out_data, out_count, out_zero, out_trunc);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL elem_or_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops [3];
        logic [15:0] exp [3];
        ops[0] = 2'b00; exp[0] = 16'h1234;
        ops[1] = 2'b10; exp[1] = 16'hEDCB;
        ops[2] = 2'b11; exp[2] = 16'hEDCB;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_beat(16'hFFFF, 16'h1234, ops[i], 1'b0, 1'b0);
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_count !== 4'd1) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: valid=%b data=%h cnt=%0d, want 1 %h 1",
                         i, out_valid, out_data, out_count, exp[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_fold_or();
        out_ready = 1'b1;
        // in_b and in_op on later beats must be ignored.
        set_beat(16'h0001, 16'hFFFF, 2'b01, 1'b1, 1'b0);
        tick();
        set_beat(16'h0010, 16'hFFFF, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fold_or_early1: valid=%b want 0", out_valid);
        end
        tick();
        set_beat(16'h0100, 16'hFFFF, 2'b11, 1'b1, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fold_or_early2: valid=%b want 0", out_valid);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0111 || out_count !== 4'd3 ||
            out_trunc !== 1'b0) begin
            n_fail++;
            $display("FAIL fold_or_result: valid=%b data=%h cnt=%0d trunc=%b, want 1 0111 3 0",
                     out_valid, out_data, out_count, out_trunc);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fold_or_single: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_fold_trunc();
        out_ready = 1'b1;
        for (int i = 0; i < MAX_BEATS; i++) begin
            set_beat(16'hFFFF, 16'h0000, 2'b00, 1'b1, 1'b0);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL trunc_early[%0d]: valid=%b want 0", i, out_valid);
            end
            tick();
        end
        // New one-beat packet enters on the same edge the truncated result drains.
        set_beat(16'h00FF, 16'h0000, 2'b01, 1'b1, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hFFFF || out_count !== 4'd8 ||
            out_trunc !== 1'b1) begin
            n_fail++;
            $display("FAIL trunc_result: valid=%b data=%h cnt=%0d trunc=%b, want 1 ffff 8 1",
                     out_valid, out_data, out_count, out_trunc);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h00FF || out_count !== 4'd1 ||
            out_trunc !== 1'b0) begin
            n_fail++;
            $display("FAIL trunc_next_pkt: valid=%b data=%h cnt=%0d trunc=%b, want 1 00ff 1 0",
                     out_valid, out_data, out_count, out_trunc);
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_beat(16'h00FF, 16'h0F0F, 2'b10, 1'b0, 1'b0);
        tick();
        set_beat(16'hFFFF, 16'h00F0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h0FF0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: rdy=%b valid=%b data=%h, want 0 1 0ff0",
                         i, in_ready, out_valid, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h00F0 || out_count !== 4'd1) begin
            n_fail++;
            $display("FAIL bp_next_beat: valid=%b data=%h cnt=%0d, want 1 00f0 1",
                     out_valid, out_data, out_count);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h00F0) begin
            n_fail++;
            $display("FAIL bp_drain: valid=%b data=%h, want 0 00f0", out_valid, out_data);
        end
    endtask

    task automatic test_reset_mid_fold();
        out_ready = 1'b1;
        set_beat(16'h1111, 16'h0000, 2'b01, 1'b1, 1'b0);
        tick();
        set_beat(16'h2222, 16'h0000, 2'b01, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_count !== 4'd0 ||
            out_trunc !== 1'b0 || out_zero !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midfold_reset: valid=%b data=%h cnt=%0d trunc=%b zero=%b rdy=%b, want 0 0000 0 0 1 0",
                     out_valid, out_data, out_count, out_trunc, out_zero, in_ready);
        end
        #2;
        reset = 1'b0;
        set_beat(16'hA5A5, 16'h0000, 2'b01, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hA5A5 || out_count !== 4'd1 ||
            out_trunc !== 1'b0) begin
            n_fail++;
            $display("FAIL fresh_fold: valid=%b data=%h cnt=%0d trunc=%b, want 1 a5a5 1 0",
                     out_valid, out_data, out_count, out_trunc);
        end
`ifdef LOGIC_UNIT_PARITY_EN
        n_checks++;
        if (out_parity !== 1'b0) begin
            n_fail++;
            $display("FAIL fresh_fold_parity: got %b want 0", out_parity);
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        @(posedge clk);
        #1;
        test_elem_or();
        test_back_to_back();
        test_fold_or();
        test_fold_trunc();
        test_backpressure();
        test_reset_mid_fold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
